load_store_unit: RTL

Memory-access stage downstream of the execute ALU. It takes the ALU result as the effective address and rs2 as store data, and runs a ready-handshake transaction on the data-memory port. It generates byte enables and store-data lane replication, and sign- or zero-extends load data. It stalls the single-cycle core until the access completes, and flags misaligned accesses and bus timeouts.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_lane_align.sv | 32 +++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, FSM states and helpers for the load/store unit
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // Byte lanes touched by an access; only meaningful for aligned sizes.
    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: be_gen = 4'b0001 << off;
            SZ_HALF: be_gen = 4'b0011 << off;
            SZ_WORD: be_gen = 4'b1111;
            default: be_gen = 4'b0000;
        endcase
    endfunction

    // Size 11 is treated as misaligned so the core takes the same trap path.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = off[0];
            SZ_WORD: is_misaligned = (off != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - shifts the addressed lane of a read word down and extends it
//
// Ports:
//   rdata_i     read word from the data memory
//   off_i       byte offset of the access within the word
//   size_i      access size (byte/half/word)
//   unsigned_i  1 = zero-extend, 0 = sign-extend
//   data_o      32-bit extended load value
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        case (size_i)
            SZ_BYTE: data_o = unsigned_i ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: data_o = unsigned_i ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: handshake, byte enables, load extension, timeout
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_write/req_size/req_unsigned/addr/wdata
//                                   load/store request from execute
//   stall                           freeze PC and write-back while an access is in flight
//   load_data/load_valid            extended load result and its one-cycle strobe
//   misaligned                      combinational reject of an unaligned/illegal request
//   bus_error                       one-cycle strobe after a timed-out access
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata/mem_ready/mem_rdata
//                                   data-memory ready-handshake port
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misaligned,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [15:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[15:0];

    lsu_state_e  state_q;
    logic [15:0] cnt_q, cnt_d;
    logic        write_q, unsigned_q;
    logic [1:0]  size_q, off_q;
    logic        mem_req_q, mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q, load_data_q;
    logic [3:0]  mem_be_q;
    logic        load_valid_q, bus_error_q;

    logic        req_bad, accept;
    logic [31:0] wdata_rep, ext_data;

    always_comb begin
        req_bad    = is_misaligned(req_size, addr[1:0]);
        accept     = (state_q == IDLE) && req_valid && !req_bad;
        misaligned = (state_q == IDLE) && req_valid && req_bad;
        stall      = accept || (state_q == WAIT);
        cnt_d      = cnt_q + 16'd1;
        case (req_size)
            SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
    end

    // Offset/size/unsigned come from the latched request so the lane
    // selection stays fixed while the core holds or changes its inputs.
    lsu_lane_align u_lane_align (
        .rdata_i    (mem_rdata),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= SZ_BYTE;
            off_q        <= 2'b00;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_be_q     <= 4'h0;
            mem_wdata_q  <= 32'h0;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q     <= req_write;
                        unsigned_q  <= req_unsigned;
                        size_q      <= req_size;
                        off_q       <= addr[1:0];
                        mem_addr_q  <= {addr[31:2], 2'b00};
                        mem_be_q    <= req_write ? be_gen(req_size, addr[1:0]) : 4'b0000;
                        mem_wdata_q <= wdata_rep;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= req_write;
                        cnt_q       <= 16'd0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (!write_q) begin
                            load_data_q  <= ext_data;
                            load_valid_q <= 1'b1;
                        end
                        state_q <= DONE;
                    end else if (cnt_q == TIMEOUT_LIMIT) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        load_data_q <= 32'h0;
                        bus_error_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                // req_valid is ignored here so the finishing instruction is not re-issued.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign bus_error  = bus_error_q;

endmodule
